imem_loader: RTL and testbench

Boot-time program loader that fills the instruction memory the CPU fetches from, before the CPU is released. It accepts a framed byte stream (valid/ready), packs little-endian bytes into 32-bit words, writes them sequentially into instruction memory, and verifies a checksum. It drives `cpu_run`, which feeds the CPU's active-low reset, so the CPU starts fetching at PC 0 only after a verified image is in place.

---
 rtl/imem_loader_pkg.sv | 27 ++
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_loader_byte_packer.sv | 36 +++
 rtl/imem_loader.sv | 127 ++++++++++++
 tb/tb_imem_loader.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------
// imem_loader_pkg : shared types and frame constants for the loader
// Rev 1.0
// ---------------------------------------------------------------------
package imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         BYTE_W    = 8;
  localparam int         LEN_W     = 16;
  localparam int         WORD_W    = 32;
  localparam int         ADDR_W    = 32;
  localparam int         LANES     = 4;
  localparam int         LANE_W    = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------
// imem_loader_if : byte stream in, instruction-memory write bus and status out
// Rev 1.0
// ---------------------------------------------------------------------
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;
  logic              cpu_run;
  logic              load_done;
  logic              load_error;

  // master is the loader itself; slave is the byte source / memory / CPU side
  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata, cpu_run, load_done, load_error
  );
  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_run, load_done, load_error
  );
endinterface
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ---------------------------------------------------------------------
// byte_packer : assembles little-endian bytes into 32-bit words
// Rev 1.0
// ---------------------------------------------------------------------
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [LANE_W-1:0]       r_lane;
  logic [3*BYTE_W-1:0]     r_low;

  // Lanes 0..2 shift in from the top, so the fourth byte completes the word directly
  assign word_valid = byte_valid && (r_lane == LANE_W'(LANES - 1));
  assign word       = {byte_in, r_low};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_lane <= '0;
      r_low  <= '0;
    end else if (byte_valid) begin
      r_lane <= r_lane + LANE_W'(1);
      r_low  <= {byte_in, r_low[3*BYTE_W-1:BYTE_W]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ---------------------------------------------------------------------
// imem_loader : framed boot loader filling instruction memory, releases CPU
// Rev 1.0
// ---------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          IMEM_WORDS = 4096,
  parameter int          TIMEOUT    = 1_000_000
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.master bus
);

  localparam logic [31:0] C_MAX_WORDS = IMEM_WORDS;
  localparam logic [31:0] C_TIMEOUT   = TIMEOUT;

  state_t              r_state;
  state_t              w_next;
  logic [BYTE_W-1:0]   r_len_lo;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_index;
  logic [BYTE_W-1:0]   r_sum;
  logic [31:0]         r_idle;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_wdata;

  logic                w_accept;
  logic                w_timed;
  logic                w_timeout;
  logic                w_is_sync;
  logic                w_frame_start;
  logic [LEN_W-1:0]    w_len_full;
  logic                w_word_valid;
  logic [WORD_W-1:0]   w_word;
  logic                w_last_word;

  assign bus.rx_ready   = (r_state != ST_DONE);
  assign bus.load_done  = (r_state == ST_DONE);
  assign bus.cpu_run    = (r_state == ST_DONE);
  assign bus.load_error = (r_state == ST_ERR);
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;

  assign w_accept      = bus.rx_valid && bus.rx_ready;
  assign w_is_sync     = (bus.rx_data == SYNC_BYTE);
  assign w_frame_start = w_accept && w_is_sync && (r_state == ST_IDLE || r_state == ST_ERR);
  assign w_len_full    = {bus.rx_data, r_len_lo};
  assign w_timed       = (r_state == ST_LEN0) || (r_state == ST_LEN1) ||
                         (r_state == ST_DATA) || (r_state == ST_CSUM);
  assign w_timeout     = (C_TIMEOUT != 32'd0) && w_timed && !w_accept && (r_idle == C_TIMEOUT);
  assign w_last_word   = w_word_valid && (({1'b0, r_index} + 17'd1) == {1'b0, r_len});

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (w_frame_start),
    .byte_valid (w_accept && (r_state == ST_DATA)),
    .byte_in    (bus.rx_data),
    .word_valid (w_word_valid),
    .word       (w_word)
  );

  always_comb begin
    w_next = r_state;
    if (w_timeout) begin
      w_next = ST_ERR;
    end else if (w_accept) begin
      case (r_state)
        ST_IDLE, ST_ERR: if (w_is_sync) w_next = ST_LEN0;
        ST_LEN0:         w_next = ST_LEN1;
        ST_LEN1: begin
          if ({16'd0, w_len_full} > C_MAX_WORDS) w_next = ST_ERR;
          else if (w_len_full == '0)             w_next = ST_CSUM;
          else                                   w_next = ST_DATA;
        end
        ST_DATA:         if (w_last_word) w_next = ST_CSUM;
        ST_CSUM:         w_next = (bus.rx_data == r_sum) ? ST_DONE : ST_ERR;
        default:         w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_len_lo <= '0;
      r_len    <= '0;
      r_index  <= '0;
      r_sum    <= '0;
      r_idle   <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state <= w_next;
      r_we    <= w_word_valid;
      if (w_accept) begin
        case (r_state)
          ST_LEN0: r_len_lo <= bus.rx_data;
          ST_LEN1: begin
            r_len   <= w_len_full;
            r_index <= '0;
            r_sum   <= '0;
          end
          ST_DATA: r_sum <= r_sum + bus.rx_data;
          default: ;
        endcase
      end
      if (w_word_valid) begin
        r_addr  <= BASE_ADDR + ({16'd0, r_index} << 2);
        r_wdata <= w_word;
        r_index <= r_index + LEN_W'(1);
      end
      // Saturates at TIMEOUT; stays zero outside the timed states or when disabled
      if (!w_timed || w_accept || C_TIMEOUT == 32'd0) r_idle <= '0;
      else if (r_idle != C_TIMEOUT)                   r_idle <= r_idle + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ---------------------------------------------------------------------
// tb_imem_loader : directed self-checking bench for imem_loader
// Rev 1.0
// ---------------------------------------------------------------------
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  frame[$];

  imem_loader_if bus();

  imem_loader #(
    .BASE_ADDR  (32'h0000_0000),
    .IMEM_WORDS (4),
    .TIMEOUT    (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.imem_we) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] q[$], input int max_gap);
    foreach (q[i]) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin @(posedge clk); #1; end
      send_byte(q[i]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rx_ready",  32'(bus.rx_ready),   32'd1);
    check("rst_we",        32'(bus.imem_we),    32'd0);
    check("rst_cpu_run",   32'(bus.cpu_run),    32'd0);
    check("rst_done",      32'(bus.load_done),  32'd0);
    check("rst_error",     32'(bus.load_error), 32'd0);
    check("rst_addr",      bus.imem_addr,       32'd0);
    check("rst_wdata",     bus.imem_wdata,      32'd0);
    reset = 1'b0;

    // Garbage before SYNC, then a good N=2 frame
    frame = '{8'h00, 8'hFF, 8'h5A};
    send_seq(frame, 0);
    check("garbage_error", 32'(bus.load_error), 32'd0);
    check("garbage_ready", 32'(bus.rx_ready),   32'd1);
    check("garbage_nwr",   32'(wr_addr.size()), 32'd0);
    frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
    send_seq(frame, 0);
    send_byte(8'h44);
    check("w0_we",   32'(bus.imem_we), 32'd1);
    check("w0_addr", bus.imem_addr,    32'h0000_0000);
    check("w0_data", bus.imem_wdata,   32'h4433_2211);
    send_byte(8'h55);
    check("we_one_cycle", 32'(bus.imem_we), 32'd0);
    frame = '{8'h66, 8'h77, 8'h88};
    send_seq(frame, 0);
    check("w1_we",      32'(bus.imem_we),   32'd1);
    check("w1_addr",    bus.imem_addr,      32'h0000_0004);
    check("w1_data",    bus.imem_wdata,     32'h8877_6655);
    check("pre_csum_done", 32'(bus.load_done), 32'd0);
    send_byte(8'h64);
    check("ok_done",    32'(bus.load_done), 32'd1);
    check("ok_cpu_run", 32'(bus.cpu_run),   32'd1);
    check("ok_ready",   32'(bus.rx_ready),  32'd0);
    check("ok_nwr",     32'(wr_addr.size()), 32'd2);

    // Bad checksum, then recovery with an N=1 frame
    do_reset();
    check("rst_drops_run", 32'(bus.cpu_run), 32'd0);
    frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88, 8'h65};
    send_seq(frame, 0);
    check("bad_error",   32'(bus.load_error), 32'd1);
    check("bad_cpu_run", 32'(bus.cpu_run),    32'd0);
    check("bad_ready",   32'(bus.rx_ready),   32'd1);
    check("bad_nwr",     32'(wr_addr.size()), 32'd4);
    check("bad_w1_addr", wr_addr[3],          32'h0000_0004);
    send_byte(8'h00);
    check("err_discard", 32'(bus.load_error), 32'd1);
    send_byte(8'hA5);
    check("sync_clears_err", 32'(bus.load_error), 32'd0);
    frame = '{8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38};
    send_seq(frame, 0);
    check("rec_done",  32'(bus.load_done), 32'd1);
    check("rec_nwr",   32'(wr_addr.size()), 32'd5);
    check("rec_addr",  wr_addr[4],          32'h0000_0000);
    check("rec_data",  wr_data[4],          32'hEFBE_ADDE);

    // Empty frame
    do_reset();
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_seq(frame, 0);
    check("n0_done", 32'(bus.load_done),  32'd1);
    check("n0_nwr",  32'(wr_addr.size()), 32'd5);

    // Length at and above capacity
    do_reset();
    frame = '{8'hA5, 8'h04, 8'h00};
    send_seq(frame, 0);
    check("n4_no_error", 32'(bus.load_error), 32'd0);
    do_reset();
    frame = '{8'hA5, 8'h05, 8'h00};
    send_seq(frame, 0);
    check("n5_error", 32'(bus.load_error), 32'd1);

    // Random valid gaps
    do_reset();
    frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
    send_seq(frame, 5);
    check("gap_done",  32'(bus.load_done),  32'd1);
    check("gap_nwr",   32'(wr_addr.size()), 32'd7);
    check("gap_w0",    wr_data[5],          32'h4433_2211);
    check("gap_a1",    wr_addr[6],          32'h0000_0004);
    check("gap_w1",    wr_data[6],          32'h8877_6655);

    // Timeout after the fifth data byte
    do_reset();
    frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_seq(frame, 0);
    repeat (16) @(posedge clk);
    #1;
    check("to_not_yet", 32'(bus.load_error), 32'd0);
    @(posedge clk); #1;
    check("to_error",   32'(bus.load_error), 32'd1);
    check("to_nwr",     32'(wr_addr.size()), 32'd8);

    // Reset coinciding with the lane-3 byte
    do_reset();
    frame = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
    send_seq(frame, 0);
    bus.rx_data  = 8'h44;
    bus.rx_valid = 1'b1;
    reset        = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    reset        = 1'b0;
    check("rstw_we",      32'(bus.imem_we),  32'd0);
    check("rstw_cpu_run", 32'(bus.cpu_run),  32'd0);
    check("rstw_ready",   32'(bus.rx_ready), 32'd1);
    @(posedge clk); #1;
    check("rstw_we_late", 32'(bus.imem_we),   32'd0);
    check("rstw_nwr",     32'(wr_addr.size()), 32'd8);
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_seq(frame, 0);
    check("rstw_idle_frame", 32'(bus.load_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
